// File: rtl/excecao_pkg.sv
// Shared types and constants for the exception sequencer: state encoding,
// cause codes and the default handler-vector addresses in data memory.
package excecao_pkg;

    typedef enum logic [2:0] {
        EST_IDLE     = 3'd0,
        EST_SAVE     = 3'd1,
        EST_MEM_REQ  = 3'd2,
        EST_MEM_WAIT = 3'd3,
        EST_LOAD_PC  = 3'd4,
        EST_RET      = 3'd5,
        EST_HALT     = 3'd6
    } estado_exc_t;

    localparam logic [63:0] CAUSA_OPCODE     = 64'd0;
    localparam logic [63:0] CAUSA_OVERFLOW   = 64'd1;

    localparam logic [63:0] VEC_OPCODE_DEF   = 64'd254;
    localparam logic [63:0] VEC_OVERFLOW_DEF = 64'd255;

    // PCOut already points past the faulting instruction; step back one word.
    function automatic logic [63:0] epc_de_pc(input logic [63:0] pc);
        return pc - 64'd4;
    endfunction

    // Handler address is a single memory byte, zero-extended.
    function automatic logic [63:0] handler_de_byte(input logic [7:0] b);
        return {56'd0, b};
    endfunction

endpackage

// File: rtl/controle_excecao_if.sv
// Port bundle between the exception sequencer (slave) and the datapath /
// control unit that feeds it events and consumes its strobes (master).
interface controle_excecao_if;

    logic        ExcOpcode;
    logic        ExcOverflow;
    logic        Eret;
    logic [63:0] PCOut;
    logic [63:0] MemDataIn;

    logic        Busy;
    logic        LoadEPC;
    logic [63:0] EPCValue;
    logic        LoadCausa;
    logic [63:0] CausaValue;
    logic [63:0] MemAddr;
    logic        MemRead;
    logic        LoadPC;
    logic [63:0] PCValue;
    logic        ExcAck;
    logic        InHandler;
    logic        Halted;

    modport slave (
        input  ExcOpcode, ExcOverflow, Eret, PCOut, MemDataIn,
        output Busy, LoadEPC, EPCValue, LoadCausa, CausaValue, MemAddr,
        output MemRead, LoadPC, PCValue, ExcAck, InHandler, Halted
    );

    modport master (
        output ExcOpcode, ExcOverflow, Eret, PCOut, MemDataIn,
        input  Busy, LoadEPC, EPCValue, LoadCausa, CausaValue, MemAddr,
        input  MemRead, LoadPC, PCValue, ExcAck, InHandler, Halted
    );

endinterface

// File: rtl/controle_excecao.sv
// Multicycle exception sequencer: saves EPC/cause, fetches the handler byte
// from data memory, redirects the PC, and handles Eret and double faults.
module controle_excecao
    import excecao_pkg::*;
#(
    parameter logic [63:0] VEC_OPCODE   = VEC_OPCODE_DEF,
    parameter logic [63:0] VEC_OVERFLOW = VEC_OVERFLOW_DEF
) (
    input  logic                 clk,
    input  logic                 Reset,
    controle_excecao_if.slave    bus
);

    estado_exc_t estado_q, estado_d;

    logic [63:0] epc_q,     epc_d;
    logic [63:0] causa_q,   causa_d;
    logic [63:0] vetor_q,   vetor_d;
    logic [63:0] handler_q, handler_d;
    logic [63:0] pc_val_q,  pc_val_d;
    logic        in_handler_q, in_handler_d;
    logic        halted_q,     halted_d;

    logic        excecao;
    logic        unused_mem_hi;

    assign excecao       = bus.ExcOpcode | bus.ExcOverflow;
    assign unused_mem_hi = ^bus.MemDataIn[63:8];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            estado_q     <= EST_IDLE;
            epc_q        <= 64'd0;
            causa_q      <= 64'd0;
            vetor_q      <= 64'd0;
            handler_q    <= 64'd0;
            pc_val_q     <= 64'd0;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            epc_q        <= epc_d;
            causa_q      <= causa_d;
            vetor_q      <= vetor_d;
            handler_q    <= handler_d;
            pc_val_q     <= pc_val_d;
            in_handler_q <= in_handler_d;
            halted_q     <= halted_d;
        end
    end

    // Exceptions outrank Eret; an exception inside a handler is fatal.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            EST_IDLE: begin
                if (excecao) begin
                    estado_d = in_handler_q ? EST_HALT : EST_SAVE;
                end else if (bus.Eret && in_handler_q) begin
                    estado_d = EST_RET;
                end
            end
            EST_SAVE:     estado_d = EST_MEM_REQ;
            EST_MEM_REQ:  estado_d = EST_MEM_WAIT;
            EST_MEM_WAIT: estado_d = EST_LOAD_PC;
            EST_LOAD_PC:  estado_d = EST_IDLE;
            EST_RET:      estado_d = EST_IDLE;
            EST_HALT:     estado_d = EST_HALT;
            default:      estado_d = EST_IDLE;
        endcase
    end

    always_comb begin
        epc_d        = epc_q;
        causa_d      = causa_q;
        vetor_d      = vetor_q;
        handler_d    = handler_q;
        pc_val_d     = pc_val_q;
        in_handler_d = in_handler_q;
        halted_d     = halted_q;
        case (estado_q)
            EST_IDLE: begin
                if (excecao && !in_handler_q) begin
                    epc_d   = epc_de_pc(bus.PCOut);
                    causa_d = bus.ExcOpcode ? CAUSA_OPCODE : CAUSA_OVERFLOW;
                    vetor_d = bus.ExcOpcode ? VEC_OPCODE   : VEC_OVERFLOW;
                end else if (excecao) begin
                    halted_d = 1'b1;
                end else if (bus.Eret && in_handler_q) begin
                    pc_val_d = epc_q;
                end
            end
            EST_MEM_WAIT: begin
                handler_d = handler_de_byte(bus.MemDataIn[7:0]);
                pc_val_d  = handler_de_byte(bus.MemDataIn[7:0]);
            end
            EST_LOAD_PC: in_handler_d = 1'b1;
            EST_RET:     in_handler_d = 1'b0;
            default: ;
        endcase
    end

    // Value outputs always show the last captured register; only strobes decode state.
    always_comb begin
        bus.Busy       = 1'b0;
        bus.LoadEPC    = 1'b0;
        bus.LoadCausa  = 1'b0;
        bus.MemRead    = 1'b0;
        bus.LoadPC     = 1'b0;
        bus.ExcAck     = 1'b0;
        bus.EPCValue   = epc_q;
        bus.CausaValue = causa_q;
        bus.MemAddr    = vetor_q;
        bus.PCValue    = pc_val_q;
        bus.InHandler  = in_handler_q;
        bus.Halted     = halted_q;
        case (estado_q)
            EST_SAVE: begin
                bus.Busy      = 1'b1;
                bus.LoadEPC   = 1'b1;
                bus.LoadCausa = 1'b1;
            end
            EST_MEM_REQ, EST_MEM_WAIT: begin
                bus.Busy    = 1'b1;
                bus.MemRead = 1'b1;
            end
            EST_LOAD_PC: begin
                bus.Busy    = 1'b1;
                bus.LoadPC  = 1'b1;
                bus.ExcAck  = 1'b1;
                bus.PCValue = handler_q;
            end
            EST_RET: begin
                bus.Busy   = 1'b1;
                bus.LoadPC = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controle_excecao.sv
// Directed bench for controle_excecao: opcode/overflow entry, return,
// double fault, mid-sequence reset, EPC wrap and handler zero-extension.
module tb_controle_excecao;

    logic       clk;
    logic       Reset;
    logic [7:0] byte254;
    logic [7:0] byte255;
    int         checks;
    int         failures;

    controle_excecao_if bus ();

    controle_excecao #(
        .VEC_OPCODE   (64'd254),
        .VEC_OVERFLOW (64'd255)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous data memory: read data valid one cycle after the address.
    always @(posedge clk) begin
        if (bus.MemAddr == 64'd254)
            bus.MemDataIn <= {56'hA5A5A5A5A5A5A5, byte254};
        else if (bus.MemAddr == 64'd255)
            bus.MemDataIn <= {56'h5A5A5A5A5A5A5A, byte255};
        else
            bus.MemDataIn <= 64'h0;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b0;
        byte254 = 8'h80;
        byte255 = 8'h24;
        bus.ExcOpcode = 1'b0;
        bus.ExcOverflow = 1'b0;
        bus.Eret = 1'b0;
        bus.PCOut = 64'h0;
        bus.MemDataIn = 64'h0;
        repeat (2) cyc();

        chk("rst_busy",    64'(bus.Busy), 64'd0);
        chk("rst_loadpc",  64'(bus.LoadPC), 64'd0);
        chk("rst_epc",     bus.EPCValue, 64'd0);
        chk("rst_memaddr", bus.MemAddr, 64'd0);
        chk("rst_inh",     64'(bus.InHandler), 64'd0);
        chk("rst_halted",  64'(bus.Halted), 64'd0);
        Reset = 1'b1;
        cyc();

        // Opcode fault from PC 0x40, handler byte 0x80.
        bus.PCOut = 64'h40;
        bus.ExcOpcode = 1'b1;
        cyc();
        bus.ExcOpcode = 1'b0;
        chk("op_save_busy",  64'(bus.Busy), 64'd1);
        chk("op_save_lepc",  64'(bus.LoadEPC), 64'd1);
        chk("op_save_lcau",  64'(bus.LoadCausa), 64'd1);
        chk("op_save_epc",   bus.EPCValue, 64'h3C);
        chk("op_save_cause", bus.CausaValue, 64'd0);
        chk("op_save_ldpc",  64'(bus.LoadPC), 64'd0);
        cyc();
        chk("op_req_rd",     64'(bus.MemRead), 64'd1);
        chk("op_req_addr",   bus.MemAddr, 64'd254);
        chk("op_req_lepc",   64'(bus.LoadEPC), 64'd0);
        cyc();
        chk("op_wait_rd",    64'(bus.MemRead), 64'd1);
        chk("op_wait_ldpc",  64'(bus.LoadPC), 64'd0);
        cyc();
        chk("op_ld_ldpc",    64'(bus.LoadPC), 64'd1);
        chk("op_ld_pcval",   bus.PCValue, 64'h80);
        chk("op_ld_ack",     64'(bus.ExcAck), 64'd1);
        chk("op_ld_busy",    64'(bus.Busy), 64'd1);
        cyc();
        chk("op_idle_ack",   64'(bus.ExcAck), 64'd0);
        chk("op_idle_busy",  64'(bus.Busy), 64'd0);
        chk("op_idle_inh",   64'(bus.InHandler), 64'd1);

        // Return from handler, then a stray second Eret.
        bus.Eret = 1'b1;
        cyc();
        bus.Eret = 1'b0;
        chk("ret_ldpc",      64'(bus.LoadPC), 64'd1);
        chk("ret_pcval",     bus.PCValue, 64'h3C);
        chk("ret_ack",       64'(bus.ExcAck), 64'd0);
        cyc();
        chk("ret_inh",       64'(bus.InHandler), 64'd0);
        chk("ret_done_ldpc", 64'(bus.LoadPC), 64'd0);
        bus.Eret = 1'b1;
        cyc();
        bus.Eret = 1'b0;
        chk("eret2_ldpc",    64'(bus.LoadPC), 64'd0);
        chk("eret2_busy",    64'(bus.Busy), 64'd0);

        // Both faults at once: opcode wins.
        bus.PCOut = 64'h100;
        bus.ExcOpcode = 1'b1;
        bus.ExcOverflow = 1'b1;
        cyc();
        bus.ExcOpcode = 1'b0;
        bus.ExcOverflow = 1'b0;
        chk("both_cause",    bus.CausaValue, 64'd0);
        chk("both_epc",      bus.EPCValue, 64'hFC);
        cyc();
        chk("both_addr",     bus.MemAddr, 64'd254);
        repeat (3) cyc();
        chk("both_inh",      64'(bus.InHandler), 64'd1);
        bus.Eret = 1'b1;
        cyc();
        bus.Eret = 1'b0;
        cyc();

        // Overflow alone, handler byte 0x24.
        bus.PCOut = 64'h200;
        bus.ExcOverflow = 1'b1;
        cyc();
        bus.ExcOverflow = 1'b0;
        chk("ovf_cause",     bus.CausaValue, 64'd1);
        chk("ovf_epc",       bus.EPCValue, 64'h1FC);
        cyc();
        chk("ovf_addr",      bus.MemAddr, 64'd255);
        repeat (2) cyc();
        chk("ovf_pcval",     bus.PCValue, 64'h24);
        cyc();

        // Double fault: overflow while still in the handler.
        bus.PCOut = 64'h300;
        bus.ExcOverflow = 1'b1;
        cyc();
        bus.ExcOverflow = 1'b0;
        chk("dbl_halted",    64'(bus.Halted), 64'd1);
        chk("dbl_busy",      64'(bus.Busy), 64'd0);
        chk("dbl_lepc",      64'(bus.LoadEPC), 64'd0);
        chk("dbl_epc_kept",  bus.EPCValue, 64'h1FC);
        bus.ExcOpcode = 1'b1;
        bus.Eret = 1'b1;
        repeat (2) cyc();
        bus.ExcOpcode = 1'b0;
        bus.Eret = 1'b0;
        chk("halt_sticky",   64'(bus.Halted), 64'd1);
        chk("halt_ldpc",     64'(bus.LoadPC), 64'd0);
        chk("halt_rd",       64'(bus.MemRead), 64'd0);
        Reset = 1'b0;
        cyc();
        chk("halt_rst",      64'(bus.Halted), 64'd0);
        Reset = 1'b1;
        cyc();

        // EPC wrap from PC 0, then reset while in MEM_WAIT.
        byte254 = 8'hFF;
        bus.PCOut = 64'h0;
        bus.ExcOpcode = 1'b1;
        cyc();
        bus.ExcOpcode = 1'b0;
        chk("wrap_epc",      bus.EPCValue, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (2) cyc();
        chk("mw_rd",         64'(bus.MemRead), 64'd1);
        Reset = 1'b0;
        #1;
        chk("mw_rst_rd",     64'(bus.MemRead), 64'd0);
        chk("mw_rst_busy",   64'(bus.Busy), 64'd0);
        chk("mw_rst_epc",    bus.EPCValue, 64'd0);
        chk("mw_rst_addr",   bus.MemAddr, 64'd0);
        cyc();
        chk("mw_rst_ldpc",   64'(bus.LoadPC), 64'd0);
        Reset = 1'b1;
        cyc();

        // Full sequence again after reset; 0xFF handler byte zero-extended.
        bus.ExcOpcode = 1'b1;
        cyc();
        bus.ExcOpcode = 1'b0;
        chk("re_save_lepc",  64'(bus.LoadEPC), 64'd1);
        repeat (3) cyc();
        chk("re_ld_ldpc",    64'(bus.LoadPC), 64'd1);
        chk("re_ld_pcval",   bus.PCValue, 64'h0000_0000_0000_00FF);
        chk("re_ld_ack",     64'(bus.ExcAck), 64'd1);
        cyc();
        chk("re_idle_inh",   64'(bus.InHandler), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_excecao.md
# controle_excecao

Multicycle exception sequencer for the RISC-V datapath. Detects an invalid-opcode or ALU-overflow event, saves the cause and the faulting PC, reads the handler address byte from data memory, and redirects the PC. It stalls the main control unit while it owns the PC and memory ports. It also handles handler return (`Eret`) and latches a double fault.

## Interface
- `VEC_OPCODE`, default 64'd254: data-memory address holding the invalid-opcode handler byte.
- `VEC_OVERFLOW`, default 64'd255: data-memory address holding the overflow handler byte.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `Reset`  in  1: asynchronous, active-low (0 = reset).
- `ExcOpcode`  in  1: invalid opcode decoded; level, sampled in IDLE.
- `ExcOverflow`  in  1: qualified ALU overflow; level, sampled in IDLE.
- `Eret`  in  1: return-from-handler request; single-cycle pulse.
- `PCOut`  in  64: current PC, already incremented past the faulting instruction.
- `MemDataIn`  in  64: data-memory read data, valid one cycle after `MemAddr`.
- `Busy`  out  1: main control unit must hold; high in every state except IDLE and HALT.
- `LoadEPC`  out  1: EPC register load strobe.
- `EPCValue`  out  64: value to write into EPC.
- `LoadCausa`  out  1: cause register load strobe.
- `CausaValue`  out  64: cause code to write.
- `MemAddr`  out  64: data-memory read address.
- `MemRead`  out  1: requests the shared data-memory port.
- `LoadPC`  out  1: PC load strobe; OR-ed into the PC load logic.
- `PCValue`  out  64: new PC value.
- `ExcAck`  out  1: one-cycle pulse when the PC is redirected to a handler.
- `InHandler`  out  1: set on handler entry, cleared on `Eret`.
- `Halted`  out  1: double fault; sticky until reset.

## Operation
- States: IDLE, SAVE, MEM_REQ, MEM_WAIT, LOAD_PC, RET, HALT. Outputs are Moore-decoded from the state and internal registers.
- IDLE, `ExcOpcode` or `ExcOverflow` high, `InHandler`=0:
  - capture EPC = `PCOut` − 4 (64-bit wrap);
  - capture cause: 0 for opcode, 1 for overflow; opcode wins if both are high;
  - capture the matching vector address;
  - go to SAVE.
- IDLE, exception high, `InHandler`=1: go to HALT (double fault). Nothing is saved.
- IDLE, `Eret` high, `InHandler`=1: go to RET. `Eret` with `InHandler`=0 is ignored.
- IDLE, exception and `Eret` high together: the exception takes priority.
- SAVE: `LoadEPC`=`LoadCausa`=1 with the captured values. Next: MEM_REQ.
- MEM_REQ: `MemRead`=1, `MemAddr`=vector. Next: MEM_WAIT.
- MEM_WAIT: `MemRead`=1, `MemAddr`=vector. At the edge, latch the handler address as `MemDataIn[7:0]` zero-extended to 64 bits. Next: LOAD_PC.
- LOAD_PC: `LoadPC`=1, `PCValue`=handler address, `ExcAck`=1, set `InHandler`. Next: IDLE.
- RET: `LoadPC`=1, `PCValue`=captured EPC, clear `InHandler`. Next: IDLE.
- HALT: `Halted`=1, `Busy`=0, all strobes 0. Stays until reset.
- `ExcOpcode`, `ExcOverflow` and `Eret` are ignored in all states except IDLE.
- When not driven by the current state: `EPCValue`, `CausaValue`, `PCValue` and `MemAddr` show their last captured value; strobes are 0.

## Timing
- Reset (async, any state, including mid-sequence): state IDLE; every output and internal register 0. The sequence in progress is abandoned with no partial strobes.
- Exception high in IDLE during cycle N:
  - SAVE in N+1;
  - MEM_REQ in N+2;
  - MEM_WAIT in N+3;
  - LOAD_PC in N+4;
  - IDLE in N+5.
- Latency from detection to `LoadPC`: 4 cycles. `Busy` is high for cycles N+1..N+4.
- `Eret` in IDLE during cycle N: RET in N+1, IDLE in N+2.
- Earliest new exception after a handler redirect: cycle N+5. It is a double fault unless `Eret` has completed.

## Structure
- Package `excecao_pkg` holds:
  - `estado_exc_t`, the state enum;
  - `CAUSA_OPCODE`=64'd0 and `CAUSA_OVERFLOW`=64'd1;
  - the default vector constants.
- Single module, no sub-module. Internal registers: state, EPC capture, cause capture, vector address, handler address, `InHandler`, `Halted`.

## Test plan
- Opcode fault: `PCOut`=0x40, `ExcOpcode` pulse, byte 0x80 at address 254 -> SAVE with `EPCValue`=0x3C and `CausaValue`=0; `MemAddr`=254; `LoadPC` with `PCValue`=0x80 four cycles after detection; `ExcAck` for 1 cycle.
- Simultaneous faults: `ExcOpcode`=`ExcOverflow`=1 -> `CausaValue`=0, `MemAddr`=254. Overflow alone -> `CausaValue`=1, `MemAddr`=255.
- Return: after handler entry, pulse `Eret` -> next cycle `LoadPC`=1 with `PCValue`=0x3C; `InHandler` drops. A second `Eret` is ignored.
- Double fault: `ExcOverflow` while `InHandler`=1 -> HALT; `Halted`=1, `Busy`=0, no strobes; stays halted until `Reset`=0.
- Reset in MEM_WAIT: assert `Reset`=0 mid-cycle -> all outputs 0 immediately, no `LoadPC`. After release the block is in IDLE and a new fault runs the full sequence.
- Wrap and extension: `PCOut`=0 -> `EPCValue`=0xFFFF_FFFF_FFFF_FFFC. Vector byte 0xFF -> `PCValue`=0x0000_0000_0000_00FF (zero-extended).
